snes_pad_emulator: RTL and testbench

Device-side end of the SNES controller serial link: presents a 12-button pad to an external SNES host (console or host-side reader FPGA).
- On each host latch, captures the local button vector.
- Shifts the captured word out on the data line, one bit per host clock rising edge, MSB (button B) first.
- Host pins are asynchronous to the local clock, so they are synchronized and edge-detected internally.
- Sits between the board's button/joystick logic and the controller connector pins.

---
 rtl/snes_pad_emulator.sv | 169 ++++++++++++++++
 tb/tb_snes_pad_emulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_emulator.sv
// rtl/snes_pad_emulator.sv - SNES controller device-side serial emulator
module snes_pad_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_166MHz,
    input  logic        reset,
    input  logic        latch_in,
    input  logic        sclk_in,
    input  logic [11:0] buttons,
    output logic        data_out,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]        LAST_BIT  = 5'd15;
    localparam logic [4:0]        FULL_CNT  = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCHED,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   latch_s;
    logic                   sclk_s;
    logic                   latch_d;
    logic                   sclk_d;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   sclk_rise;

    logic [15:0]       shift_reg, shift_n;
    logic [4:0]        bit_cnt, bit_cnt_n;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic              frame_done_n;
    logic              timeout_n;
    logic              data_out_n;
    logic [15:0]       frame_word;

    // Pressed buttons go out as 0; the four trailing ID bits are always 1.
    assign frame_word = {~buttons, 4'b1111};

    // Pin synchronizers plus one delayed copy for edge detection; reset to 1 so idle-high sclk never fakes an edge.
    always_ff @(posedge clk_166MHz) begin
        if (reset) begin
            latch_sync <= '1;
            sclk_sync  <= '1;
            latch_d    <= 1'b1;
            sclk_d     <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            latch_d    <= latch_s;
            sclk_d     <= sclk_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_d;
    assign latch_fall = ~latch_s & latch_d;
    assign sclk_rise  = sclk_s & ~sclk_d;

    // FSM and datapath registers.
    always_ff @(posedge clk_166MHz) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= 16'hFFFF;
            bit_cnt    <= 5'd0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
            data_out   <= 1'b1;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_cnt_n;
            idle_cnt   <= idle_cnt_n;
            frame_done <= frame_done_n;
            timeout    <= timeout_n;
            data_out   <= data_out_n;
        end
    end

    // Next-state logic; a latch rising edge overrides every other event, including a coincident sclk edge.
    always_comb begin
        state_n      = state;
        shift_n      = shift_reg;
        bit_cnt_n    = bit_cnt;
        idle_cnt_n   = idle_cnt;
        frame_done_n = 1'b0;
        timeout_n    = 1'b0;

        if (latch_rise) begin
            state_n    = ST_LATCHED;
            shift_n    = frame_word;
            bit_cnt_n  = 5'd0;
            idle_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt_n  = 5'd0;
                    idle_cnt_n = '0;
                end
                ST_LATCHED: begin
                    // Transparent: the word captured is whatever is present when the latch drops.
                    shift_n = frame_word;
                    if (latch_fall) begin
                        state_n    = ST_SHIFT;
                        bit_cnt_n  = 5'd0;
                        idle_cnt_n = '0;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        shift_n    = {shift_reg[14:0], 1'b0};
                        idle_cnt_n = '0;
                        if (bit_cnt >= LAST_BIT) begin
                            bit_cnt_n    = FULL_CNT;
                            state_n      = ST_DONE;
                            frame_done_n = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // Host stopped clocking: abandon the frame.
                        state_n    = ST_IDLE;
                        timeout_n  = 1'b1;
                        bit_cnt_n  = 5'd0;
                        idle_cnt_n = '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt_n = idle_cnt + IDLE_W'(1);
                    end
                end
                ST_DONE: begin
                    idle_cnt_n = '0;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Serial output for the following cycle: idle high, current MSB while framing, low once the frame is complete.
    always_comb begin
        data_out_n = 1'b1;
        case (state)
            ST_IDLE:    data_out_n = 1'b1;
            ST_LATCHED: data_out_n = shift_reg[15];
            ST_SHIFT:   data_out_n = shift_reg[15];
            ST_DONE:    data_out_n = 1'b0;
            default:    data_out_n = 1'b1;
        endcase
    end

    assign busy = (state == ST_LATCHED) || (state == ST_SHIFT);

endmodule

// File: tb/tb_snes_pad_emulator.sv
// tb/tb_snes_pad_emulator.sv - self-checking bench for snes_pad_emulator
module tb_snes_pad_emulator;

    localparam int SYNC = 2;
    localparam int TMO  = 300;

    logic        clk_166MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        latch_in   = 1'b0;
    logic        sclk_in    = 1'b1;
    logic [11:0] buttons    = 12'h000;
    logic        data_out;
    logic        busy;
    logic        frame_done;
    logic        timeout;

    int errors   = 0;
    int checks   = 0;
    int fd_count = 0;
    int to_count = 0;
    int half     = 6;

    always #3 clk_166MHz = ~clk_166MHz;

    snes_pad_emulator #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_166MHz(clk_166MHz),
        .reset     (reset),
        .latch_in  (latch_in),
        .sclk_in   (sclk_in),
        .buttons   (buttons),
        .data_out  (data_out),
        .busy      (busy),
        .frame_done(frame_done),
        .timeout   (timeout)
    );

    // Pulse counters for the one-cycle status outputs.
    always @(negedge clk_166MHz) begin
        if (frame_done === 1'b1) fd_count++;
        if (timeout === 1'b1) to_count++;
    end

    // Reference: bits go out B..R as "not pressed", then four ID ones, then zeros forever.
    function automatic int model_bit(input logic [11:0] pressed, input int k);
        if (k < 12) return (pressed[11-k] === 1'b1) ? 0 : 1;
        else if (k < 16) return 1;
        else return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk_166MHz);
    endtask

    task automatic do_latch(input logic [11:0] b);
        buttons  = b;
        latch_in = 1'b1;
        hold(half);
        latch_in = 1'b0;
        hold(half);
    endtask

    // One host clock period; the host samples data just before the rising edge.
    task automatic sclk_pulse(output int s);
        sclk_in = 1'b0;
        hold(half);
        s = int'(data_out);
        sclk_in = 1'b1;
        hold(half);
    endtask

    task automatic shift_and_check(input logic [11:0] b, input string tag);
        int s;
        int fd0;
        fd0 = fd_count;
        check({tag, "_busy_pre"}, int'(busy), 1);
        for (int k = 0; k < 17; k++) begin
            sclk_pulse(s);
            check($sformatf("%s_bit%0d", tag, k), s, model_bit(b, k));
        end
        hold(2);
        check({tag, "_frame_done"}, fd_count - fd0, 1);
        check({tag, "_busy_post"}, int'(busy), 0);
    endtask

    task automatic run_frame(input logic [11:0] b, input string tag);
        do_latch(b);
        shift_and_check(b, tag);
    endtask

    initial begin
        int s;
        int fd0;
        int to0;
        int nonzero;
        logic [11:0] rb;

        // Reset held with pins toggling.
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            latch_in = 1'($urandom);
            sclk_in  = 1'($urandom);
            hold(1);
        end
        check("rst_data_out", int'(data_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_no_pulses", fd_count + to_count, 0);
        latch_in = 1'b0;
        sclk_in  = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(6);
        check("post_rst_data_out", int'(data_out), 1);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_no_pulses", fd_count + to_count, 0);

        // Full frame with B and R pressed.
        run_frame(12'h801, "b_r");

        // Buttons change while latch is high; value at latch fall is sent.
        buttons  = 12'h000;
        latch_in = 1'b1;
        hold(3);
        buttons = 12'h010;
        hold(half);
        latch_in = 1'b0;
        hold(half);
        shift_and_check(12'h010, "transparent");

        // Restart mid-frame.
        do_latch(12'h000);
        fd0 = fd_count;
        for (int i = 0; i < 5; i++) sclk_pulse(s);
        buttons  = 12'h800;
        latch_in = 1'b1;
        hold(half);
        check("restart_bit_b", int'(data_out), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_no_done", fd_count - fd0, 0);
        latch_in = 1'b0;
        hold(half);
        shift_and_check(12'h800, "restart");

        // Timeout: host stops after three clocks.
        to0 = to_count;
        fd0 = fd_count;
        do_latch(12'($urandom));
        for (int i = 0; i < 3; i++) sclk_pulse(s);
        check("tmo_busy_before", int'(busy), 1);
        hold(TMO + 10);
        check("tmo_pulse", to_count - to0, 1);
        check("tmo_data_out", int'(data_out), 1);
        check("tmo_busy", int'(busy), 0);
        check("tmo_no_done", fd_count - fd0, 0);

        // Coincident latch and sclk rising edges mid-frame: latch wins.
        do_latch(12'h0F0);
        for (int i = 0; i < 4; i++) sclk_pulse(s);
        sclk_in = 1'b0;
        hold(half);
        buttons  = 12'h5A3;
        latch_in = 1'b1;
        sclk_in  = 1'b1;
        hold(half);
        check("simul_bit_b", int'(data_out), model_bit(12'h5A3, 0));
        latch_in = 1'b0;
        hold(half);
        shift_and_check(12'h5A3, "simul");

        // Extra clocks in DONE: data stays low, no extra frame_done.
        fd0 = fd_count;
        nonzero = 0;
        for (int i = 0; i < 16; i++) begin
            sclk_pulse(s);
            if (s != 0) nonzero++;
        end
        check("done_extra_bits_low", nonzero, 0);
        check("done_extra_no_pulse", fd_count - fd0, 0);
        check("done_busy", int'(busy), 0);

        // Reset asserted mid-frame.
        do_latch(12'h3C3);
        for (int i = 0; i < 3; i++) sclk_pulse(s);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        hold(3);
        check("midrst_busy", int'(busy), 0);
        check("midrst_data_out", int'(data_out), 1);
        rb = 12'($urandom);
        run_frame(rb, "after_midrst");

        // Randomized frames with varied host timing.
        for (int n = 0; n < 6; n++) begin
            half = int'($urandom_range(10, SYNC + 2));
            rb = 12'($urandom);
            run_frame(rb, $sformatf("rand%0d", n));
        end

        check("no_stray_timeouts", to_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
